// File: rtl/mem_pattern_tester.sv
// mem_pattern_tester: memory read/write self-test engine for an Avalon-style master.
// A test has two passes over addresses 0..addr_last. The first pass writes a
// selectable pattern. The second pass reads every location back and compares it
// against the same pattern.
// Waitrequest stalls a request, which then holds address/data stable. One read is
// outstanding at a time.
// Optional feature: define MEM_TEST_STOP_ON_ERR_EN to end the test at the first
// read mismatch instead of scanning the whole range.
module mem_pattern_tester #(
  parameter int                ADDR_W        = 24,
  parameter int                DATA_W        = 16,
  parameter int                ERR_W         = 16,
  parameter logic [DATA_W-1:0] CONST_PATTERN = 16'h5555,
  parameter logic [DATA_W-1:0] LFSR_SEED     = 16'hACE1,
  parameter logic [DATA_W-1:0] LFSR_TAPS     = 16'hB400
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] addr_last,
  output logic [ADDR_W-1:0] address,
  output logic              write,
  output logic [DATA_W-1:0] writedata,
  output logic              read,
  input  logic [DATA_W-1:0] readdata,
  input  logic              waitrequest,
  input  logic              readdatavalid,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WR    = 3'd1;
  localparam logic [2:0] S_TURN0 = 3'd2;
  localparam logic [2:0] S_TURN1 = 3'd3;
  localparam logic [2:0] S_RD    = 3'd4;
  localparam logic [2:0] S_RWAIT = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  localparam logic [ADDR_W-1:0] DATA_W_A = ADDR_W'(DATA_W);
  localparam logic [DATA_W-1:0] ONE_HOT0 = DATA_W'(1);

  logic [2:0]        state;
  logic [1:0]        mode_q;
  logic [ADDR_W-1:0] addr_last_q;
  logic [DATA_W-1:0] lfsr;

  logic [ADDR_W-1:0] addr_inc;
  logic              at_last;
  logic [DATA_W-1:0] lfsr_step;
  logic [DATA_W-1:0] expected_data;
  logic [DATA_W-1:0] next_wr_data;
  logic [DATA_W-1:0] first_wr_data;
  logic              mismatch;
  logic [ERR_W-1:0]  err_next;
  logic              stop_now;

  // The pattern for one address.
  // The LFSR value is passed in because it already tracks the current beat number.
  function automatic logic [DATA_W-1:0] pattern(
    input logic [1:0]        m,
    input logic [ADDR_W-1:0] a,
    input logic [DATA_W-1:0] l
  );
    logic [DATA_W+ADDR_W-1:0] wide;
    logic [ADDR_W-1:0]        bitpos;
    logic [DATA_W-1:0]        result;
    wide              = '0;
    wide[ADDR_W-1:0]  = a;
    bitpos            = a % DATA_W_A;
    case (m)
      2'd0:    result = CONST_PATTERN;
      2'd1:    result = wide[DATA_W-1:0];
      2'd2:    result = ONE_HOT0 << bitpos;
      default: result = l;
    endcase
    return result;
  endfunction

  // Next-beat address, pattern values and compare result derived from the current registers
  always_comb begin
    addr_inc      = address + ADDR_W'(1);
    at_last       = (address == addr_last_q);
    lfsr_step     = {lfsr[DATA_W-2:0], ^(lfsr & LFSR_TAPS)};
    expected_data = pattern(mode_q, address, lfsr);
    next_wr_data  = pattern(mode_q, addr_inc, lfsr_step);
    first_wr_data = pattern(mode, '0, LFSR_SEED);
    mismatch      = (readdata != expected_data);
    err_next      = (mismatch && !(&err_count)) ? err_count + ERR_W'(1) : err_count;
`ifdef MEM_TEST_STOP_ON_ERR_EN
    stop_now      = at_last | mismatch;
`else
    stop_now      = at_last;
`endif
  end

  // Test sequencer: write pass, fixed turnaround, read/compare pass, result hold
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      mode_q         <= 2'd0;
      addr_last_q    <= '0;
      lfsr           <= '0;
      address        <= '0;
      write          <= 1'b0;
      writedata      <= '0;
      read           <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      fail           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state          <= S_WR;
            mode_q         <= mode;
            addr_last_q    <= addr_last;
            lfsr           <= LFSR_SEED;
            address        <= '0;
            write          <= 1'b1;
            writedata      <= first_wr_data;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            fail           <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
          end
        end
        S_WR: begin
          if (!waitrequest) begin
            if (at_last) begin
              write <= 1'b0;
              state <= S_TURN0;
            end else begin
              address   <= addr_inc;
              writedata <= next_wr_data;
              lfsr      <= lfsr_step;
            end
          end
        end
        S_TURN0: begin
          state <= S_TURN1;
        end
        S_TURN1: begin
          state   <= S_RD;
          address <= '0;
          read    <= 1'b1;
          lfsr    <= LFSR_SEED;
        end
        S_RD: begin
          if (!waitrequest) begin
            read  <= 1'b0;
            state <= S_RWAIT;
          end
        end
        S_RWAIT: begin
          if (readdatavalid) begin
            err_count <= err_next;
            if (mismatch && (err_count == '0)) begin
              first_err_addr <= address;
            end
            if (stop_now) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_next == '0);
              fail  <= (err_next != '0);
            end else begin
              state   <= S_RD;
              address <= addr_inc;
              lfsr    <= lfsr_step;
              read    <= 1'b1;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          write <= 1'b0;
          read  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_pattern_tester.sv
// tb_mem_pattern_tester: randomized bench for mem_pattern_tester.
// A memory slave model and a beat monitor run at every falling edge. A second
// instance with a 4-bit error counter exercises saturation against an
// always-wrong slave.
module tb_mem_pattern_tester;

  localparam int ADDR_W = 24;
  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [1:0]        mode = 2'd0;
  logic [ADDR_W-1:0] addr_last = '0;
  logic [ADDR_W-1:0] address;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              read;
  logic [DATA_W-1:0] readdata = '0;
  logic              waitrequest = 1'b0;
  logic              readdatavalid = 1'b0;
  logic              busy, done, pass, fail;
  logic [15:0]       err_count;
  logic [ADDR_W-1:0] first_err_addr;

  logic              start_s = 1'b0;
  logic [ADDR_W-1:0] address_s;
  logic              write_s;
  logic [DATA_W-1:0] writedata_s;
  logic              read_s;
  logic              readdatavalid_s = 1'b0;
  logic              busy_s, done_s, pass_s, fail_s;
  logic [3:0]        err_count_s;
  logic [ADDR_W-1:0] first_err_addr_s;
  logic              last_read_s = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] mem    [0:255];
  logic [15:0] wr_log [0:255];
  bit [255:0]  corrupt = '0;
  bit          rand_wait = 1'b0;
  bit          rand_lat = 1'b0;
  int          cur_mode = 0;
  int          wr_count = 0;
  int          rd_count = 0;
  int          write_cycles = 0;
  logic              prev_write = 1'b0, prev_read = 1'b0, prev_wait = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;
  logic [DATA_W-1:0] prev_data = '0;
  bit          pend_active = 1'b0;
  int          pend_cnt = 0;
  logic [15:0] pend_data = '0;
  bit          waiting_read = 1'b0;
  int          gap = 0;

  always #5 clk = ~clk;

  mem_pattern_tester dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .addr_last(addr_last),
    .address(address), .write(write), .writedata(writedata), .read(read),
    .readdata(readdata), .waitrequest(waitrequest), .readdatavalid(readdatavalid),
    .busy(busy), .done(done), .pass(pass), .fail(fail),
    .err_count(err_count), .first_err_addr(first_err_addr)
  );

  mem_pattern_tester #(.ERR_W(4)) dut_sat (
    .clk(clk), .rst(rst), .start(start_s), .mode(2'd0), .addr_last(24'd31),
    .address(address_s), .write(write_s), .writedata(writedata_s), .read(read_s),
    .readdata(16'h0000), .waitrequest(1'b0), .readdatavalid(readdatavalid_s),
    .busy(busy_s), .done(done_s), .pass(pass_s), .fail(fail_s),
    .err_count(err_count_s), .first_err_addr(first_err_addr_s)
  );

  // Reference pattern for beat idx, straight from the pattern definitions
  function automatic logic [15:0] ref_pattern(input int m, input int idx);
    logic [15:0] v;
    case (m)
      0: v = 16'h5555;
      1: v = idx[15:0];
      2: v = 16'h0001 << (idx % 16);
      default: begin
        v = 16'hACE1;
        for (int k = 0; k < idx; k++) v = {v[14:0], ^(v & 16'hB400)};
      end
    endcase
    return v;
  endfunction

  // Expected error count, first failing address and number of reads for a range
  task automatic model_result(input int m, input int last,
                              output int err, output int first, output int nreads);
    err = 0; first = 0; nreads = last + 1;
    for (int i = 0; i <= last; i++) begin
      if (corrupt[i] && (ref_pattern(m, i) !== 16'h0000)) begin
        if (err == 0) first = i;
        err++;
      end
    end
`ifdef MEM_TEST_STOP_ON_ERR_EN
    if (err > 0) begin
      err = 1;
      nreads = first + 1;
    end
`endif
  endtask

  // Memory slave plus beat monitor. Requests are sampled at the falling edge and
  // acted on one falling edge later.
  always @(negedge clk) begin
    if (rst) begin
      waitrequest = 1'b0; readdatavalid = 1'b0; readdata = '0;
      pend_active = 1'b0; prev_write = 1'b0; prev_read = 1'b0; prev_wait = 1'b0;
      waiting_read = 1'b0;
    end else begin
      readdatavalid = 1'b0;
      if (prev_write && !prev_wait) begin
        vectors++;
        if (prev_addr !== 24'(wr_count) || prev_data !== ref_pattern(cur_mode, wr_count)) begin
          miscompares++;
          $display("[TB] FAIL wr_beat %0d: got addr=%0h data=%h, want addr=%0h data=%h",
                   wr_count, prev_addr, prev_data, wr_count, ref_pattern(cur_mode, wr_count));
        end
        mem[prev_addr[7:0]]    = prev_data;
        wr_log[prev_addr[7:0]] = prev_data;
        wr_count++;
        waiting_read = 1'b1;
        gap = 0;
      end
      if (prev_read && !prev_wait) begin
        vectors++;
        if (prev_addr !== 24'(rd_count)) begin
          miscompares++;
          $display("[TB] FAIL rd_beat %0d: got addr=%0h, want %0h", rd_count, prev_addr, rd_count);
        end
        rd_count++;
        pend_active = 1'b1;
        pend_cnt = rand_lat ? int'($urandom_range(0, 3)) : 0;
        pend_data = corrupt[prev_addr[7:0]] ? 16'h0000 : mem[prev_addr[7:0]];
      end
      if (pend_active) begin
        if (pend_cnt == 0) begin
          readdatavalid = 1'b1;
          readdata = pend_data;
          pend_active = 1'b0;
        end else begin
          pend_cnt--;
        end
      end
      if (prev_write && prev_wait) begin
        vectors++;
        if (write !== 1'b1 || address !== prev_addr || writedata !== prev_data) begin
          miscompares++;
          $display("[TB] FAIL wr_hold: got w=%b a=%0h d=%h, want w=1 a=%0h d=%h",
                   write, address, writedata, prev_addr, prev_data);
        end
      end
      if (prev_read && prev_wait) begin
        vectors++;
        if (read !== 1'b1 || address !== prev_addr) begin
          miscompares++;
          $display("[TB] FAIL rd_hold: got r=%b a=%0h, want r=1 a=%0h", read, address, prev_addr);
        end
      end
      if (waiting_read) begin
        if (write) begin
          waiting_read = 1'b0;
        end else if (read) begin
          vectors++;
          if (gap !== 2) begin
            miscompares++;
            $display("[TB] FAIL turnaround: got %0d idle cycles, want 2", gap);
          end
          waiting_read = 1'b0;
        end else begin
          gap++;
        end
      end
      if (write) write_cycles++;
      prev_write = write;
      prev_read  = read;
      prev_addr  = address;
      prev_data  = writedata;
      waitrequest = (rand_wait && (write || read)) ? 1'($urandom_range(0, 1)) : 1'b0;
      prev_wait  = waitrequest;
    end
  end

  // Always-wrong ideal slave for the saturating instance: data valid one cycle after read
  always @(negedge clk) begin
    if (rst) begin
      readdatavalid_s = 1'b0;
      last_read_s = 1'b0;
    end else begin
      readdatavalid_s = last_read_s;
      last_read_s = read_s;
    end
  end

  task automatic prepare(input int m, input bit rw, input bit rl);
    cur_mode = m; wr_count = 0; rd_count = 0; write_cycles = 0;
    corrupt = '0; rand_wait = rw; rand_lat = rl;
  endtask

  task automatic pulse_start(input int m, input int last);
    @(negedge clk);
    mode = 2'(m); addr_last = 24'(last); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin ok = 1'b1; break; end
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("[TB] FAIL done_timeout: got done=%b after %0d cycles, want 1", done, budget);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({busy, done, pass, fail} !== 4'b0000) begin
      miscompares++; $display("[TB] FAIL rst_status: got %b, want 0000", {busy, done, pass, fail});
    end
    vectors++;
    if ({write, read} !== 2'b00 || address !== '0 || writedata !== '0) begin
      miscompares++; $display("[TB] FAIL rst_bus: got w=%b r=%b a=%0h d=%h, want all 0", write, read, address, writedata);
    end
    vectors++;
    if (err_count !== '0 || first_err_addr !== '0) begin
      miscompares++; $display("[TB] FAIL rst_err: got %0d/%0h, want 0/0", err_count, first_err_addr);
    end
    vectors++;
    if ({busy_s, done_s, err_count_s} !== 6'd0) begin
      miscompares++; $display("[TB] FAIL rst_sat: got %b, want 0", {busy_s, done_s, err_count_s});
    end
  endtask

  // Checks a finished run against the model for the given mode and range
  task automatic test_run(input string name, input int m, input int last,
                          input bit rw, input bit rl, input int ncorrupt);
    int exp_err, exp_first, exp_reads;
    prepare(m, rw, rl);
    for (int i = 0; i < ncorrupt; i++) corrupt[$urandom_range(0, last)] = 1'b1;
    model_result(m, last, exp_err, exp_first, exp_reads);
    pulse_start(m, last);
    wait_done(20000);
    vectors++;
    if (pass !== (exp_err == 0) || fail !== (exp_err != 0) || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL %s_flags: got pass=%b fail=%b busy=%b, want pass=%b", name, pass, fail, busy, exp_err == 0);
    end
    vectors++;
    if (err_count !== 16'(exp_err) || first_err_addr !== 24'(exp_first)) begin
      miscompares++;
      $display("[TB] FAIL %s_err: got %0d@%0h, want %0d@%0h", name, err_count, first_err_addr, exp_err, exp_first);
    end
    vectors++;
    if (wr_count !== last + 1 || rd_count !== exp_reads) begin
      miscompares++;
      $display("[TB] FAIL %s_beats: got wr=%0d rd=%0d, want wr=%0d rd=%0d", name, wr_count, rd_count, last + 1, exp_reads);
    end
  endtask

  task automatic test_const_ideal();
    test_run("const", 0, 15, 1'b0, 1'b0, 0);
    vectors++;
    if (write_cycles !== 16) begin
      miscompares++; $display("[TB] FAIL back_to_back: got %0d write cycles, want 16", write_cycles);
    end
  endtask

  task automatic test_corrupt();
    int exp_err, exp_first, exp_reads;
    prepare(1, 1'b0, 1'b0);
    corrupt[3] = 1'b1; corrupt[5] = 1'b1;
    model_result(1, 7, exp_err, exp_first, exp_reads);
    pulse_start(1, 7);
    wait_done(500);
    vectors++;
    if (fail !== 1'b1 || pass !== 1'b0) begin
      miscompares++; $display("[TB] FAIL corrupt_flags: got pass=%b fail=%b, want 0/1", pass, fail);
    end
    vectors++;
`ifdef MEM_TEST_STOP_ON_ERR_EN
    if (err_count !== 16'd1 || first_err_addr !== 24'd3 || rd_count !== 4) begin
`else
    if (err_count !== 16'd2 || first_err_addr !== 24'd3 || rd_count !== 8) begin
`endif
      miscompares++;
      $display("[TB] FAIL corrupt_err: got %0d@%0h rd=%0d, want %0d@3 rd=%0d", err_count, first_err_addr, rd_count, exp_err, exp_reads);
    end
  endtask

  task automatic test_walking();
    test_run("walking", 2, 31, 1'b1, 1'b0, 0);
    vectors++;
    if (wr_log[17] !== 16'h0002) begin
      miscompares++; $display("[TB] FAIL walking_17: got %h, want 0002", wr_log[17]);
    end
  endtask

  task automatic test_saturate();
    @(negedge clk); start_s = 1'b1;
    @(negedge clk); start_s = 1'b0;
    for (int c = 0; c < 1000 && done_s !== 1'b1; c++) @(negedge clk);
    vectors++;
`ifdef MEM_TEST_STOP_ON_ERR_EN
    if (done_s !== 1'b1 || fail_s !== 1'b1 || pass_s !== 1'b0 || err_count_s !== 4'd1 || first_err_addr_s !== '0) begin
`else
    if (done_s !== 1'b1 || fail_s !== 1'b1 || pass_s !== 1'b0 || err_count_s !== 4'd15 || first_err_addr_s !== '0) begin
`endif
      miscompares++;
      $display("[TB] FAIL saturate: got done=%b fail=%b pass=%b err=%0d first=%0h", done_s, fail_s, pass_s, err_count_s, first_err_addr_s);
    end
  endtask

  task automatic test_reset_mid();
    bit hit = 1'b0;
    prepare(0, 1'b0, 1'b0);
    pulse_start(0, 15);
    for (int c = 0; c < 300; c++) begin
      if (read === 1'b1 && address === 24'd10) begin hit = 1'b1; break; end
      @(negedge clk);
    end
    vectors++;
    if (!hit) begin
      miscompares++; $display("[TB] FAIL rst_mid_reach: got no read at address a, want one");
    end
    rst = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({read, write, busy, done, pass, fail} !== 6'd0 || address !== '0 || err_count !== '0) begin
      miscompares++;
      $display("[TB] FAIL rst_mid: got r=%b w=%b busy=%b done=%b a=%0h err=%0d, want all 0", read, write, busy, done, address, err_count);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_start_busy();
    int exp_err, exp_first, exp_reads;
    prepare(0, 1'b1, 1'b1);
    model_result(0, 15, exp_err, exp_first, exp_reads);
    pulse_start(0, 15);
    repeat (4) @(negedge clk);
    pulse_start(1, 3);
    wait_done(5000);
    vectors++;
    if (pass !== 1'b1 || wr_count !== 16 || rd_count !== exp_reads) begin
      miscompares++;
      $display("[TB] FAIL start_busy: got pass=%b wr=%0d rd=%0d, want 1/16/%0d", pass, wr_count, rd_count, exp_reads);
    end
  endtask

  initial begin
    test_reset();
    test_const_ideal();
    test_corrupt();
    test_run("lfsr", 3, 255, 1'b1, 1'b1, 0);
    test_walking();
    test_run("single", int'($urandom_range(0, 3)), 0, 1'b1, 1'b1, 0);
    for (int r = 0; r < 4; r++)
      test_run("random", int'($urandom_range(0, 3)), int'($urandom_range(1, 63)), 1'b1, 1'b1, int'($urandom_range(0, 4)));
    test_saturate();
    test_reset_mid();
    test_start_busy();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
